// File: rtl/dmem_responder.sv
// Single-cycle data-memory responder: byte-lane RAM, memory-mapped cycle counter,
// and a fault pulse for unmapped accesses. Read latency is one cycle, no stalls.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] CNT_ADDR    = 32'hFFFF_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dmem_addr,
  input  logic [3:0]  i_dmem_mask,
  input  logic [31:0] i_dmem_wdata,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_rvalid,
  output logic        o_fault
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   cnt;
  logic [31:0]   cnt_inc;
  logic [31:0]   cnt_next;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          cnt_hit;
  logic          unmapped;

  // Address decode and next counter value (masked lanes of a counter write win).
  always_comb begin
    idx      = i_dmem_addr[AW+1:2];
    in_range = {1'b0, i_dmem_addr} < SPAN_BYTES;
    cnt_hit  = !in_range && (i_dmem_addr[31:2] == CNT_ADDR[31:2]);
    unmapped = !in_range && !cnt_hit;
    cnt_inc  = cnt + 32'd1;
    cnt_next = cnt_inc;
    if (i_dmem_wen && cnt_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_mask[b]) begin
          cnt_next[8*b +: 8] = i_dmem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Data array: byte-lane writes, suppressed while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_dmem_wen && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_mask[b]) begin
          mem[idx][8*b +: 8] <= i_dmem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Counter reads return the value the counter takes at the request edge,
  // ignoring any same-edge counter write (read-first).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt           <= '0;
      o_dmem_rdata  <= '0;
      o_dmem_rvalid <= 1'b0;
      o_fault       <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      o_dmem_rvalid <= i_dmem_ren;
      o_fault       <= (i_dmem_ren || i_dmem_wen) && unmapped;
      if (i_dmem_ren) begin
        if (in_range) begin
          o_dmem_rdata <= mem[idx];
        end else if (cnt_hit) begin
          o_dmem_rdata <= cnt_inc;
        end else begin
          o_dmem_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the data array (power of two, at least 4).
REQ-002 SHALL have parameter CNT_ADDR, default 32'hFFFF_0000: word address of the memory-mapped cycle counter.
REQ-003 i_clk  input  1  single clock, all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_dmem_addr  input  32  byte address; bits [1:0] ignored.
REQ-006 i_dmem_mask  input  4  byte-lane write enables; bit n selects wdata[8n+7:8n].
REQ-007 i_dmem_wdata  input  32  lane-aligned store data.
REQ-008 i_dmem_ren  input  1  read request, sampled at each rising edge.
REQ-009 i_dmem_wen  input  1  write request, sampled at each rising edge.
REQ-010 o_dmem_rdata  output  32  full read word, lane-aligned.
REQ-011 o_dmem_rvalid  output  1  one-cycle pulse: o_dmem_rdata carries the response.
REQ-012 o_fault  output  1  one-cycle pulse: the request sampled at the previous edge hit an unmapped address.

Function
REQ-013 Address decode:
- Word index = i_dmem_addr[log2(DEPTH_WORDS)+1:2].
- In range: i_dmem_addr < DEPTH_WORDS*4.
- Counter hit: i_dmem_addr[31:2] == CNT_ADDR[31:2].
- Any other address is unmapped.
REQ-014 Write, in range and i_dmem_wen=1: SHALL update only byte lanes with a mask bit of 1 at the rising edge; wen=1 with mask=4'b0000 SHALL change nothing.
REQ-015 Read, i_dmem_ren=1: o_dmem_rdata SHALL present the full addressed word one cycle after the sampling edge (latency 1), and o_dmem_rvalid SHALL be 1 for exactly that cycle.
REQ-016 With no read sampled, o_dmem_rvalid SHALL be 0 and o_dmem_rdata SHALL hold its last value.
REQ-017 ren=1 and wen=1 sampled together: SHALL perform the write and return the pre-write word (read-first).
REQ-018 Write at edge N followed by read of the same word at edge N+1: SHALL return the newly written data.
REQ-019 Back-to-back reads on consecutive edges SHALL each produce a response, giving a continuous rvalid.
REQ-020 Cycle counter: 32-bit; SHALL increment by 1 every cycle when not reset; SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-021 Counter read: SHALL return the counter value as sampled at the request edge.
REQ-022 Counter write: SHALL load the masked byte lanes of wdata into the counter at that edge, overriding the increment for that cycle; unmasked lanes SHALL take the incremented value.
REQ-023 Unmapped write: SHALL modify no state and SHALL pulse o_fault in the next cycle.
REQ-024 Unmapped read: SHALL return 32'h0000_0000 with o_dmem_rvalid=1, and SHALL pulse o_fault in the same cycle.
REQ-025 When no request is sampled, o_fault SHALL be 0.
REQ-026 No back-pressure: every sampled request SHALL complete, with no stall or ready signal.

Reset
REQ-027 While i_rst=1: o_dmem_rdata=0, o_dmem_rvalid=0, o_fault=0, counter=0; the array SHALL NOT be written, and its contents are unspecified.
REQ-028 A request sampled while i_rst=1 SHALL be dropped, with no write and no response.
REQ-029 When i_rst is asserted mid-response, outputs SHALL go to reset values immediately (asynchronously).
REQ-030 After i_rst deasserts, the first edge SHALL accept requests normally, and the counter SHALL read 1 after that first edge.

Verification
REQ-031 Byte-lane write:
- Write 32'h1122_3344 mask 4'b1111 to addr 0x10.
- Write 32'hAABB_CCDD mask 4'b0101 to addr 0x10.
- Read addr 0x10 -> rdata 32'h11BB_33DD, rvalid=1 one cycle later.
REQ-032 Same-cycle read/write:
- Word 0x20 holds 32'h0000_0001.
- Assert ren=1, wen=1, mask=4'b1111, wdata 32'h0000_0002 on addr 0x20 -> rdata 32'h0000_0001.
- Next read of 0x20 -> 32'h0000_0002.
REQ-033 Write-then-read:
- Write 32'hDEAD_BEEF to 0x3FC at edge N.
- Read 0x3FC at edge N+1 -> 32'hDEAD_BEEF.
- Issue reads over 3 consecutive cycles -> rvalid high for 3 consecutive cycles.
REQ-034 Unmapped access, DEPTH_WORDS=1024:
- Write to 0x0000_1000 -> o_fault pulses; no array word changes.
- Read 0x0000_1000 -> rdata 0, rvalid=1, o_fault=1.
REQ-035 Counter:
- Write 32'hFFFF_FFFE mask 4'b1111 to CNT_ADDR.
- Read on the following two edges -> 32'hFFFF_FFFF, then 32'h0000_0000 (wrap).
REQ-036 Reset:
- Assert i_rst during a pending read response -> rvalid drops to 0 immediately.
- Write issued during reset -> target word is unchanged on a later read.
